// File: rtl/mem_serial.sv
// Memory-access pipeline stage: passes ALU results through and runs loads/stores
// as little-endian byte-serial transfers on an 8-bit, 1-cycle-latency RAM port.
module mem_serial (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  mem_op_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  input  logic        mem_busy_i,
  input  logic [7:0]  mem_din_i,
  output logic [31:0] mem_a_o,
  output logic [7:0]  mem_dout_o,
  output logic        mem_wr_o,
  output logic        mem_req_o,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        stallreq
);

  localparam int unsigned DW  = 32;
  localparam int unsigned AW  = 32;
  localparam int unsigned BW  = 8;
  localparam int unsigned IW  = 2;

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LH  = 4'd2;
  localparam logic [3:0] OP_LW  = 4'd3;
  localparam logic [3:0] OP_LBU = 4'd4;
  localparam logic [3:0] OP_LHU = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  typedef enum logic [1:0] {IDLE, XFER, WAIT, DONE} state_t;

  state_t          state, state_d;
  logic [IW-1:0]   cnt, cnt_d;
  logic            pend;
  logic [IW-1:0]   pend_idx;
  logic [DW-1:0]   buffer;

  logic            is_load, is_store, is_mem;
  logic [IW-1:0]   last_idx;
  logic            issue;
  logic [IW-1:0]   idx;
  logic            stall;
  logic            wreg_c;
  logic [DW-1:0]   wdata_c;
  logic [DW-1:0]   load_val;

  // Operation decode: codes outside 1..8 behave as NONE.
  always_comb begin
    is_load  = (mem_op_i >= OP_LB) && (mem_op_i <= OP_LHU);
    is_store = (mem_op_i >= OP_SB) && (mem_op_i <= OP_SW);
    is_mem   = is_load || is_store;
    last_idx = '0;
    case (mem_op_i)
      OP_LH, OP_LHU, OP_SH: last_idx = 2'd1;
      OP_LW, OP_SW:         last_idx = 2'd3;
      default:              last_idx = 2'd0;
    endcase
  end

  // Sign/zero extension of the assembled load buffer.
  always_comb begin
    load_val = '0;
    case (mem_op_i)
      OP_LB:   load_val = {{24{buffer[7]}}, buffer[7:0]};
      OP_LH:   load_val = {{16{buffer[15]}}, buffer[15:0]};
      OP_LW:   load_val = buffer;
      OP_LBU:  load_val = {24'd0, buffer[7:0]};
      OP_LHU:  load_val = {16'd0, buffer[15:0]};
      default: load_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      pend     <= 1'b0;
      pend_idx <= '0;
      buffer   <= '0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      pend     <= issue && !is_store;
      pend_idx <= idx;
      // Read data arrives one cycle after issue, independent of busy.
      if (pend) buffer[{pend_idx, 3'b000} +: BW] <= mem_din_i;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    issue   = 1'b0;
    idx     = '0;
    stall   = 1'b0;
    wreg_c  = 1'b0;
    wdata_c = '0;
    case (state)
      IDLE: begin
        if (!is_mem) begin
          wreg_c  = wreg_i;
          wdata_c = wdata_i;
        end else begin
          stall = 1'b1;
          if (!mem_busy_i) begin
            issue = 1'b1;
            cnt_d = 2'd1;
            if (last_idx == 2'd0) state_d = is_store ? DONE : WAIT;
            else                  state_d = XFER;
          end
        end
      end
      XFER: begin
        stall = 1'b1;
        if (!mem_busy_i) begin
          issue = 1'b1;
          idx   = cnt;
          cnt_d = cnt + 2'd1;
          if (cnt == last_idx) state_d = is_store ? DONE : WAIT;
        end
      end
      WAIT: begin
        stall   = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        wreg_c  = wreg_i;
        wdata_c = is_store ? '0 : load_val;
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are combinational; reset forces them all low immediately.
  always_comb begin
    mem_req_o  = rst && issue;
    mem_wr_o   = rst && issue && is_store;
    mem_a_o    = (rst && issue) ? mem_addr_i + AW'(idx) : '0;
    mem_dout_o = (rst && issue && is_store) ? mem_wdata_i[{idx, 3'b000} +: BW] : '0;
    wd_o       = rst ? wd_i : '0;
    wreg_o     = rst && wreg_c;
    wdata_o    = rst ? wdata_c : '0;
    stallreq   = rst && stall;
  end

endmodule
